sorted_stream_reader: RTL and testbench

- Drains a sorted N-entry byte array from an external synchronous-read memory port and emits it as a valid/ready stream, lowest address first.
- Sits downstream of the in-place merge sorter. It is the reader for the sorter's result memory, and feeds result consumers and testbench scoreboards.
- Optional in-line monotonicity checker flags the first out-of-order element.

---
 rtl/sorted_stream_reader.sv | 82 ++++++++
 tb/tb_sorted_stream_reader.sv | 123 ++++++++++++
 2 files changed

// File: rtl/sorted_stream_reader.sv
// sorted_stream_reader: streams an N-entry sync-read memory out as valid/ready, lowest address first.
// Defining SORTED_STREAM_ORDER_CHECK_EN adds a checker that flags the first descending pair.
module sorted_stream_reader #(
  parameter int N = 1024,
  parameter int LOG2N = 10,
  parameter int W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             mem_rd_en,
  output logic [LOG2N-1:0] mem_addr,
  input  logic [W-1:0]     mem_rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  output logic             order_err,
  output logic [LOG2N-1:0] err_index
);
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, DONE} state_t;
  state_t state, state_n;
  logic [LOG2N:0] idx;
  logic accept, xfer, at_end;
  assign accept = (state == IDLE || state == DONE) && start;
  assign xfer = state == SEND && out_ready;
  assign at_end = idx == (LOG2N+1)'(N - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    busy = 1'b0;
    done = 1'b0;
    mem_rd_en = 1'b0;
    out_valid = 1'b0;
    out_last = 1'b0;
    mem_addr = idx[LOG2N-1:0];
    state_n = accept ? READ :
              state == READ ? CAPTURE :
              state == CAPTURE ? SEND :
              xfer ? (at_end ? DONE : READ) : state;
    busy = state == READ || state == CAPTURE || state == SEND;
    done = state == DONE;
    mem_rd_en = state == READ;
    out_valid = state == SEND;
    out_last = state == SEND && at_end;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      idx <= '0;
      out_data <= '0;
    end else begin
      if (accept) idx <= '0;
      else if (xfer && !at_end) idx <= idx + 1'b1;
      if (state == CAPTURE) out_data <= mem_rd_data;
    end
`ifdef SORTED_STREAM_ORDER_CHECK_EN
  logic [W-1:0] prev;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      prev <= '0;
      order_err <= 1'b0;
      err_index <= '0;
    end else if (accept) begin
      prev <= '0;
      order_err <= 1'b0;
      err_index <= '0;
    end else if (xfer) begin
      prev <= out_data;
      if (idx != '0 && out_data < prev && !order_err) begin
        order_err <= 1'b1;
        err_index <= idx[LOG2N-1:0];
      end
    end
`else
  assign order_err = 1'b0;
  assign err_index = '0;
`endif
endmodule

// File: tb/tb_sorted_stream_reader.sv
// tb_sorted_stream_reader: directed checks of sorted_stream_reader with N=8.
module tb_sorted_stream_reader;
  localparam int N = 8;
  localparam int LOG2N = 3;
  localparam int W = 8;
`ifdef SORTED_STREAM_ORDER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b1;
  logic busy, done, mem_rd_en, out_valid, out_last, order_err;
  logic [LOG2N-1:0] mem_addr, err_index;
  logic [W-1:0] mem_rd_data, out_data;
  logic [W-1:0] mem [N];
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  always @(posedge clock) if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  sorted_stream_reader #(.N(N), .LOG2N(LOG2N), .W(W)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .order_err(order_err), .err_index(err_index)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic rst_checks();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_order_err", order_err, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", out_data, 0);
    check("rst_err_index", err_index, 0);
  endtask
  task automatic run_pass(input int stall_k, input int stall_len, input int pulse_k,
                          input int abort_k, input logic exp_err, input logic [LOG2N-1:0] exp_idx);
    int w;
    @(negedge clock);
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
    check("rd_en_first", mem_rd_en, 1);
    check("addr_first", mem_addr, 0);
    w = 1;
    for (int k = 0; k < N; k++) begin
      if (k == abort_k) begin
        reset = 1'b1;
        #1;
        rst_checks();
        @(negedge clock);
        reset = 1'b0;
        return;
      end
      while (!out_valid && w < 10) begin
        @(negedge clock);
        start = 1'b0;
        w++;
      end
      check("gap", w, 3);
      if (!out_valid) return;
      check("data", out_data, mem[k]);
      check("last", out_last, k == N - 1);
      if (k == stall_k) begin
        out_ready = 1'b0;
        repeat (stall_len) begin
          @(negedge clock);
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, mem[k]);
        end
        out_ready = 1'b1;
      end
      if (k == pulse_k) start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      w = 1;
    end
    check("end_valid", out_valid, 0);
    check("end_last", out_last, 0);
    check("end_busy", busy, 0);
    check("end_done", done, 1);
    check("end_order_err", order_err, exp_err);
    check("end_err_index", err_index, exp_idx);
  endtask
  initial begin
    repeat (2) @(negedge clock);
    rst_checks();
    reset = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = W'(i);
    run_pass(-1, 0, -1, -1, 1'b0, 3'd0);
    for (int i = 0; i < N; i++) mem[i] = W'(10 + i);
    run_pass(2, 5, -1, -1, 1'b0, 3'd0);
    mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 9;
    mem[4] = 4; mem[5] = 5; mem[6] = 6; mem[7] = 7;
    run_pass(-1, 0, -1, -1, CHK, CHK ? 3'd4 : 3'd0);
    for (int i = 0; i < N; i++) mem[i] = 8'd5;
    run_pass(-1, 0, -1, -1, 1'b0, 3'd0);
    mem[0] = 3; mem[1] = 2; mem[2] = 1; mem[3] = 0;
    mem[4] = 4; mem[5] = 5; mem[6] = 6; mem[7] = 7;
    run_pass(-1, 0, -1, -1, CHK, CHK ? 3'd1 : 3'd0);
    for (int i = 0; i < N; i++) mem[i] = W'(i);
    run_pass(-1, 0, 3, -1, 1'b0, 3'd0);
    run_pass(-1, 0, -1, 3, 1'b0, 3'd0);
    run_pass(-1, 0, -1, -1, 1'b0, 3'd0);
    run_pass(-1, 0, -1, -1, 1'b0, 3'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
